mod_mult_serial: RTL and testbench

Parametrised bit-serial modular multiplier computing m = (a × b) mod N for WIDTH-bit operands, for use in the RSA datapath. It takes a start pulse, runs one double-and-add iteration per clock, pulses finish with a registered result, and reports invalid operands through an error flag. It generalises the fixed 256-bit doubling product block with these additions:

- configurable width;
- busy/error status;
- operand latching;
- optional early termination.

---
 rtl/mod_mult_serial.sv | 108 ++++++++++
 tb/tb_mod_mult_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_mult_serial.sv
// Bit-serial modular multiplier: m = (a * b) mod N via LSB-first double-and-add.
// Optional feature: define MOD_MULT_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module mod_mult_serial #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] m,
  output logic             finish,
  output logic             busy,
  output logic             error
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] n_q, t_q, s_q, acc_q;
  logic [CntW-1:0]  cnt_q;
  // Operation bypasses the iterations (operand fault or zero multiplier) but still
  // spends one CALC cycle so finish lands one edge after accept.
  logic             skip_q;

  logic [WIDTH:0]   sum, sum_red, dbl, dbl_red;
  logic [WIDTH-1:0] acc_nxt, t_nxt, s_nxt;
  logic             last_iter, fault, empty_a;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, t_q};
    sum_red   = (sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum;
    acc_nxt   = s_q[0] ? sum_red[WIDTH-1:0] : acc_q;
    dbl       = {t_q, 1'b0};
    dbl_red   = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    t_nxt     = dbl_red[WIDTH-1:0];
    s_nxt     = s_q >> 1;
    fault     = (N == '0) || (b >= N);
`ifdef MOD_MULT_EARLY_EXIT_EN
    last_iter = (cnt_q == LastCnt) || (s_nxt == '0);
    empty_a   = (a == '0);
`else
    last_iter = (cnt_q == LastCnt);
    empty_a   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      t_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      m       <= '0;
      finish  <= 1'b0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      finish <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q     <= N;
            t_q     <= b;
            s_q     <= a;
            acc_q   <= '0;
            cnt_q   <= '0;
            skip_q  <= fault || empty_a;
            m       <= '0;
            error   <= fault;
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (skip_q) begin
            skip_q  <= 1'b0;
            finish  <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q <= acc_nxt;
            t_q   <= t_nxt;
            s_q   <= s_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              m       <= acc_nxt;
              finish  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_serial.sv
// Directed self-checking bench for mod_mult_serial at WIDTH=16, both exit-mode builds.
module tb_mod_mult_serial;

`ifdef MOD_MULT_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] N = '0, a = '0, b = '0;
  logic [15:0] m;
  logic        finish, busy, error;

  int n_cmp = 0;
  int n_bad = 0;

  mod_mult_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .a(a), .b(b),
    .m(m), .finish(finish), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Expected edges from accept to finish.
  function automatic int exp_lat(input logic [15:0] ea, input logic [15:0] eb,
                                 input logic [15:0] en);
    if (en == 16'd0 || eb >= en) return 1;
    if (!Early) return 16;
    if (ea == 16'd0) return 1;
    for (int i = 15; i >= 0; i--) if (ea[i]) return i + 1;
    return 1;
  endfunction

  // Pulse start with operands, wait for finish, then step into IDLE.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] tn,
                       output int lat, output logic [15:0] rm, output logic re);
    @(negedge clk);
    a = ta; b = tb_v; N = tn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; rm = 'x; re = 1'bx;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (finish) begin lat = k; rm = m; re = error; end
    end
    if (lat > 0) @(posedge clk);
  endtask

  task automatic test_reset();
    int lat;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m !== 16'd0) begin n_bad++; $display("FAIL reset_m got %h want 0000", m); end
    n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish got %b want 0", finish); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
    // Start presented in the first cycle after reset release.
    @(negedge clk);
    rst = 1'b0; a = 16'd3; b = 16'd11; N = 16'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL post_reset_accept busy got %b want 1", busy); end
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (finish) lat = k;
    end
    n_cmp++; if (lat !== exp_lat(16'd3, 16'd11, 16'd13) || m !== 16'd7) begin
      n_bad++; $display("FAIL post_reset_op got lat=%0d m=%0d want lat=%0d m=7", lat, m,
                        exp_lat(16'd3, 16'd11, 16'd13));
    end
    @(posedge clk);
  endtask

  task automatic test_product(input logic [15:0] ta, input logic [15:0] tb_v,
                              input logic [15:0] tn, input logic [15:0] em, input logic ee);
    int lat; logic [15:0] rm; logic re;
    do_op(ta, tb_v, tn, lat, rm, re);
    n_cmp++; if (rm !== em) begin
      n_bad++; $display("FAIL product_m a=%h b=%h N=%h got %h want %h", ta, tb_v, tn, rm, em);
    end
    n_cmp++; if (re !== ee) begin
      n_bad++; $display("FAIL product_error a=%h b=%h N=%h got %b want %b", ta, tb_v, tn, re, ee);
    end
    n_cmp++; if (lat !== exp_lat(ta, tb_v, tn)) begin
      n_bad++; $display("FAIL product_latency a=%h got %0d want %0d", ta, lat, exp_lat(ta, tb_v, tn));
    end
  endtask

  task automatic test_busy_window();
    int lat; bit ok;
    ok = 1'b1; lat = -1;
    @(negedge clk);
    a = 16'd279; b = 16'd198; N = 16'd221; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1) ok = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) ok = 1'b0;
      if (finish) lat = k;
    end
    @(posedge clk); #1;
    n_cmp++; if (ok !== 1'b1 || lat !== exp_lat(16'd279, 16'd198, 16'd221)) begin
      n_bad++; $display("FAIL busy_window got ok=%b lat=%0d want ok=1 lat=%0d", ok, lat,
                        exp_lat(16'd279, 16'd198, 16'd221));
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall got %b want 0", busy); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    lat = -1;
    @(negedge clk);
    a = 16'd279; b = 16'd198; N = 16'd221; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd3; b = 16'd11; N = 16'd13;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 5) start = 1'b0;
      if (finish) lat = k;
    end
    n_cmp++; if (m !== 16'd213) begin n_bad++; $display("FAIL busy_start_m got %0d want 213", m); end
    n_cmp++; if (lat !== exp_lat(16'd279, 16'd198, 16'd221)) begin
      n_bad++; $display("FAIL busy_start_latency got %0d want %0d", lat,
                        exp_lat(16'd279, 16'd198, 16'd221));
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    @(negedge clk);
    a = 16'd3; b = 16'd11; N = 16'd13; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (finish) lat = k;
    end
    n_cmp++; if (lat < 0 || m !== 16'd7) begin
      n_bad++; $display("FAIL b2b_first got lat=%0d m=%0d want m=7", lat, m);
    end
    a = 16'd1; b = 16'd5; N = 16'd7;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle busy got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept busy got %b want 1", busy); end
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (finish) lat = k;
    end
    n_cmp++; if (lat !== exp_lat(16'd1, 16'd5, 16'd7) || m !== 16'd5) begin
      n_bad++; $display("FAIL b2b_second got lat=%0d m=%0d want lat=%0d m=5", lat, m,
                        exp_lat(16'd1, 16'd5, 16'd7));
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    int seen; int lat; logic [15:0] rm; logic re;
    @(negedge clk);
    a = 16'd279; b = 16'd198; N = 16'd221; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({m, finish, busy, error} !== 19'd0) begin
      n_bad++; $display("FAIL midreset_outputs got m=%h f=%b busy=%b err=%b want all 0",
                        m, finish, busy, error);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (finish || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin
      n_bad++; $display("FAIL midreset_no_finish got %0d active cycles want 0", seen);
    end
    do_op(16'd3, 16'd11, 16'd13, lat, rm, re);
    n_cmp++; if (rm !== 16'd7 || re !== 1'b0) begin
      n_bad++; $display("FAIL midreset_followup got m=%0d err=%b want m=7 err=0", rm, re);
    end
  endtask

  initial begin
    test_reset();
    test_product(16'd3, 16'd11, 16'd13, 16'd7, 1'b0);
    test_product(16'd279, 16'd198, 16'd221, 16'd213, 1'b0);
    test_busy_window();
    test_product(16'd5, 16'd13, 16'd13, 16'd0, 1'b1);
    test_product(16'd5, 16'd0, 16'd0, 16'd0, 1'b1);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_product(16'hFFFF, 16'hFFFE, 16'hFFFF, 16'd0, 1'b0);
    test_product(16'd1, 16'd5, 16'd7, 16'd5, 1'b0);
    test_product(16'd0, 16'd5, 16'd7, 16'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
